// File: rtl/branch_predictor_pkg.sv
// Shared branch predictor definitions: counter encodings and default table geometry.
// The pipeline sizes its carried prediction fields from the same defaults.
package branch_predictor_pkg;

    localparam int BP_IDX_BITS = 6;
    localparam int BP_TAG_BITS = 8;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter next-state: count up on taken, down on not-taken,
// holding at the ends.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur,
    input  logic       taken,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken && cur != BP_ST)
            nxt = cur + 2'd1;
        else if (!taken && cur != BP_SNT)
            nxt = cur - 2'd1;
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: combinational lookup by fetch PC, training
// and mispredict/redirect generation from the resolved EX-stage branch.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = BP_IDX_BITS,
    parameter int TAG_BITS = BP_TAG_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_mispredict
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_LO  = IDX_BITS + 2;
    localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

    logic                valid_q  [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic [1:0]          ctr_nxt;

    assign if_idx = if_pc[TAG_LO-1:2];
    assign if_tag = if_pc[TAG_HI:TAG_LO];
    assign ex_idx = ex_pc[TAG_LO-1:2];
    assign ex_tag = ex_pc[TAG_HI:TAG_LO];

    // Lookup sees state from the last edge; same-cycle updates are not bypassed.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : pc_plus4(if_pc);

    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_counter2 u_ctr (
        .cur   (ctr_q[ex_idx]),
        .taken (ex_taken),
        .nxt   (ctr_nxt)
    );

    logic do_train, do_alloc, do_inval;
    assign do_train = ex_valid && ex_is_branch && ex_hit;
    assign do_alloc = ex_valid && ex_is_branch && !ex_hit && ex_taken;
    assign do_inval = ex_valid && !ex_is_branch && ex_hit;

    always_comb begin
        mispredict = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch)
                mispredict = (ex_taken != ex_pred_taken) ||
                             (ex_taken && ex_target != ex_pred_target);
            else
                mispredict = ex_pred_taken;
        end
    end

    assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : pc_plus4(ex_pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= BP_WNT;
            end
        end else if (do_train) begin
            ctr_q[ex_idx] <= ctr_nxt;
        end else if (do_alloc) begin
            valid_q[ex_idx] <= 1'b1;
            ctr_q[ex_idx]   <= BP_WT;
        end else if (do_inval) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

    // Tag/target need no reset: they are only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (do_alloc)
                tag_q[ex_idx] <= ex_tag;
            if (do_alloc || (do_train && ex_taken))
                target_q[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            perf_mispredict <= '0;
        else if (mispredict)
            perf_mispredict <= perf_mispredict + 32'd1;
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0], if_pc[31:TAG_HI+1], ex_pc[31:TAG_HI+1]};

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a behavioural table model held in plain arrays.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc, perf_mispredict;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .perf_mispredict(perf_mispredict)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: 64 entries, 8-bit tags, counter held as an integer 0..3.
    bit          m_valid [64];
    int unsigned m_tag   [64];
    logic [31:0] m_target[64];
    int          m_ctr   [64];
    logic [31:0] m_perf;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'd63);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] pc);
        return (pc >> 8) & 32'd255;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_perf = 0;
    endtask

    task automatic m_pred(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i  = idx_of(pc);
        tk = m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
        tg = tk ? m_target[i] : pc + 32'd4;
    endtask

    task automatic m_update();
        int i;
        bit hit;
        i   = idx_of(ex_pc);
        hit = m_valid[i] && m_tag[i] == tag_of(ex_pc);
        if (ex_is_branch) begin
            if (hit) begin
                m_ctr[i] = ex_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                    : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
                if (ex_taken) m_target[i] = ex_target;
            end else if (ex_taken) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(ex_pc);
                m_target[i] = ex_target;
                m_ctr[i]    = 2;
            end
        end else if (hit) begin
            m_valid[i] = 0;
        end
    endtask

    task automatic drive_ex(input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tg,
                            input logic ptk, input logic [31:0] ptg);
        ex_valid = v; ex_is_branch = br; ex_pc = pc; ex_taken = tk;
        ex_target = tg; ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic clear_ex();
        drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    // One clock: check combinational outputs, then advance model and check the counter.
    task automatic cycle();
        logic        etk, emis;
        logic [31:0] etg, ered;
        #1;
        m_pred(if_pc, etk, etg);
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, etk});
        chk("pred_target", pred_target, etg);
        emis = 0;
        if (ex_valid)
            emis = ex_is_branch ? (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target))
                                : ex_pred_taken;
        ered = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
        chk("mispredict", {31'b0, mispredict}, {31'b0, emis});
        if (emis) chk("redirect_pc", redirect_pc, ered);
        @(posedge clk);
        if (rst) m_reset();
        else begin
            if (emis) m_perf = m_perf + 1;
            if (ex_valid) m_update();
        end
        #1;
        chk("perf_mispredict", perf_mispredict, m_perf);
        @(negedge clk);
    endtask

    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        logic        ptk;
        logic [31:0] ptg;
        m_pred(pc, ptk, ptg);
        drive_ex(1, 1, pc, tk, tg, ptk, ptg);
        cycle();
        clear_ex();
    endtask

    function automatic logic [31:0] rand_pc();
        return ({$urandom_range(0, 3)} << 8) | ({$urandom_range(0, 7)} << 2);
    endfunction

    task automatic random_cycles(input int n);
        logic        ptk;
        logic [31:0] ptg, pc;
        for (int k = 0; k < n; k++) begin
            if_pc = ($urandom_range(0, 9) == 0) ? $urandom & ~32'h3 : rand_pc();
            pc = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : rand_pc();
            m_pred(pc, ptk, ptg);
            if ($urandom_range(0, 4) == 0) ptk = ~ptk;
            if ($urandom_range(0, 4) == 0) ptg = rand_pc();
            if ($urandom_range(0, 3) == 0)
                drive_ex($urandom_range(0, 1), 0, pc, 0, 32'h0, ptk, ptg);
            else
                drive_ex($urandom_range(0, 3) != 0, 1, pc, $urandom_range(0, 1),
                         rand_pc() + 32'h1000, ptk, ptg);
            cycle();
        end
        clear_ex();
    endtask

    initial begin
        rst = 1; if_pc = 32'h100; clear_ex();
        m_reset();
        @(negedge clk);
        cycle();
        rst = 0;

        // Reset state
        #1;
        chk("t1_pred_taken", {31'b0, pred_taken}, 32'd0);
        chk("t1_pred_target", pred_target, 32'h104);
        chk("t1_perf", perf_mispredict, 32'd0);
        cycle();

        // First taken branch allocates at WT
        drive_ex(1, 1, 32'h100, 1, 32'h80, 0, 32'h104);
        #1;
        chk("t2_mispredict", {31'b0, mispredict}, 32'd1);
        chk("t2_redirect", redirect_pc, 32'h80);
        cycle();
        clear_ex();
        #1;
        chk("t2_pred_taken", {31'b0, pred_taken}, 32'd1);
        chk("t2_pred_target", pred_target, 32'h80);
        chk("t2_perf", perf_mispredict, 32'd1);
        cycle();

        // Saturation ST -> WT -> WNT
        repeat (3) train(32'h100, 1, 32'h80);
        train(32'h100, 0, 32'h80);
        #1 chk("t3_after_1nt", {31'b0, pred_taken}, 32'd1);
        train(32'h100, 0, 32'h80);
        #1 chk("t3_after_2nt", {31'b0, pred_taken}, 32'd0);
        cycle();

        // Alias: non-branch hitting a trained entry invalidates it
        train(32'h200, 1, 32'h300);
        if_pc = 32'h200;
        #1 chk("t4_trained", {31'b0, pred_taken}, 32'd1);
        drive_ex(1, 0, 32'h200, 0, 32'h0, 1, 32'h300);
        #1;
        chk("t4_mispredict", {31'b0, mispredict}, 32'd1);
        chk("t4_redirect", redirect_pc, 32'h204);
        cycle();
        clear_ex();
        #1 chk("t4_invalidated", {31'b0, pred_taken}, 32'd0);

        // Same-cycle update is not visible to lookup
        drive_ex(1, 1, 32'h200, 1, 32'h240, 0, 32'h204);
        #1 chk("t5_same_cycle", {31'b0, pred_taken}, 32'd0);
        cycle();
        clear_ex();
        #1;
        chk("t5_next_cycle", {31'b0, pred_taken}, 32'd1);
        chk("t5_target", pred_target, 32'h240);

        // PC wrap on redirect
        drive_ex(1, 1, 32'hFFFF_FFFC, 0, 32'h10, 1, 32'h10);
        #1;
        chk("t6_mispredict", {31'b0, mispredict}, 32'd1);
        chk("t6_redirect_wrap", redirect_pc, 32'h0);
        cycle();
        clear_ex();

        random_cycles(300);

        // Reset mid-stream discards everything
        rst = 1;
        cycle();
        rst = 0;
        for (int k = 0; k < 32; k++) begin
            if_pc = rand_pc();
            #1 chk("t6_post_rst", {31'b0, pred_taken}, 32'd0);
            cycle();
        end
        if_pc = 32'hFFFF_FFFC;
        #1 chk("t6_wrap_target", pred_target, 32'h0);
        cycle();

        for (int r = 0; r < 4; r++) begin
            random_cycles(150);
            rst = 1;
            cycle();
            rst = 0;
        end
        random_cycles(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
